// File: rtl/axi_dma_w_burst_pkg.sv
// rtl/axi_dma_w_burst_pkg.sv - AXI field widths, codes and FSM states for the write-DMA master
package axi_dma_w_burst_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 1;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_BUF  = 4'b0010;
    localparam logic [AXI_PROT_W-1:0]  AXI_PROT_DATA  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/axi_dma_w_burst_if.sv
// rtl/axi_dma_w_burst_if.sv - AXI4 write address/data/response channels with master/slave views
interface axi_dma_w_burst_if
    import axi_dma_w_burst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8
) ();

    logic [AXI_ID_W-1:0]    awid;
    logic [ADDR_W-1:0]      awaddr;
    logic [LEN_W-1:0]       awlen;
    logic [AXI_SIZE_W-1:0]  awsize;
    logic [AXI_BURST_W-1:0] awburst;
    logic [AXI_LOCK_W-1:0]  awlock;
    logic [AXI_CACHE_W-1:0] awcache;
    logic [AXI_PROT_W-1:0]  awprot;
    logic [AXI_QOS_W-1:0]   awqos;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W/8-1:0]    wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;
    logic [AXI_RESP_W-1:0]  bresp;
    logic                   bvalid;
    logic                   bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_dma_w_burst_burst_len.sv
// rtl/axi_dma_w_burst_burst_len.sv - next burst length: min(remaining, MAX_BURST, beats to 4 KB)
module axi_dma_burst_len #(
    parameter int XFER_W    = 16,
    parameter int MAX_BURST = 256
) (
    input  logic [XFER_W-1:0] remaining,
    input  logic [XFER_W:0]   beats_to_4k,
    output logic [XFER_W:0]   blen
);

    localparam logic [XFER_W:0] MAX_B = (XFER_W+1)'(MAX_BURST);

    logic [XFER_W:0] rem_ext;
    logic [XFER_W:0] capped;

    always_comb begin
        rem_ext = {1'b0, remaining};
        capped  = (rem_ext < MAX_B) ? rem_ext : MAX_B;
        blen    = (capped < beats_to_4k) ? capped : beats_to_4k;
    end

endmodule

// File: rtl/axi_dma_w_burst.sv
// rtl/axi_dma_w_burst.sv - AXI4 write-DMA master splitting a command into 4 KB-safe INCR bursts
module axi_dma_w_burst
    import axi_dma_w_burst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 8,
    parameter int MAX_BURST = 256,
    parameter int XFER_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [XFER_W-1:0]   cmd_beats,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_strb,
    output logic                busy,
    output logic                done,
    output logic                error,
    axi_dma_w_burst_if.master   m_axi
);

    localparam int SHIFT = $clog2(DATA_W/8);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [XFER_W-1:0] remaining;
    logic [LEN_W:0]    blen;
    logic [LEN_W-1:0]  beat;
    logic [LEN_W-1:0]  awlen;
    logic              done_nxt;

    logic [12:0]       bytes_to_4k;
    logic [XFER_W:0]   beats_to_4k;
    logic [XFER_W:0]   blen_calc;
    logic [ADDR_W-1:0] addr_aligned;
    logic [ADDR_W-1:0] blen_bytes;
    logic              aw_fire, w_fire, b_fire, last_beat, final_burst;
    logic              awvalid, wvalid, wlast, bready;
    logic              unused_bits;

    assign addr_aligned = {cmd_addr[ADDR_W-1:SHIFT], SHIFT'(0)};
    assign unused_bits  = ^{cmd_addr[SHIFT-1:0], blen_calc[XFER_W:LEN_W+1]};

    // Bytes left before the next 4 KB page; 4096 when already page-aligned.
    assign bytes_to_4k = 13'h1000 - {1'b0, addr[11:0]};
    assign beats_to_4k = (XFER_W+1)'(bytes_to_4k >> SHIFT);
    assign blen_bytes  = ADDR_W'(blen) << SHIFT;
    assign awlen       = blen[LEN_W-1:0] - LEN_W'(1);

    axi_dma_burst_len #(
        .XFER_W    (XFER_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_len (
        .remaining   (remaining),
        .beats_to_4k (beats_to_4k),
        .blen        (blen_calc)
    );

    assign aw_fire     = (state == ST_ADDR) && m_axi.awready;
    assign w_fire      = (state == ST_DATA) && s_valid && m_axi.wready;
    assign b_fire      = (state == ST_RESP) && m_axi.bvalid;
    assign last_beat   = (beat == awlen);
    assign final_burst = (remaining == XFER_W'(blen));

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        s_ready   = 1'b0;
        bready    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_beats == '0) done_nxt  = 1'b1;
                    else                 state_nxt = ST_CALC;
                end
            end
            ST_CALC: state_nxt = ST_ADDR;
            ST_ADDR: begin
                awvalid = 1'b1;
                if (m_axi.awready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                wvalid  = s_valid;
                s_ready = m_axi.wready;
                wlast   = last_beat;
                if (w_fire && last_beat) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bready = 1'b1;
                if (m_axi.bvalid) begin
                    if (final_burst) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_CALC;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            blen      <= '0;
            beat      <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (state == ST_IDLE && cmd_valid) begin
                addr      <= addr_aligned;
                remaining <= cmd_beats;
                error     <= 1'b0;
            end
            if (state == ST_CALC) blen <= blen_calc[LEN_W:0];
            if (aw_fire)          beat <= '0;
            if (w_fire)           beat <= beat + LEN_W'(1);
            // Errors accumulate; the transfer runs to completion regardless.
            if (b_fire) begin
                error     <= error | (m_axi.bresp != AXI_RESP_OKAY);
                remaining <= remaining - XFER_W'(blen);
                addr      <= addr + blen_bytes;
            end
        end
    end

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = addr;
    assign m_axi.awlen   = awlen;
    assign m_axi.awsize  = AXI_SIZE_W'(SHIFT);
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awlock  = '0;
    assign m_axi.awcache = AXI_CACHE_BUF;
    assign m_axi.awprot  = AXI_PROT_DATA;
    assign m_axi.awqos   = '0;
    assign m_axi.awvalid = awvalid;
    assign m_axi.wdata   = s_data;
    assign m_axi.wstrb   = s_strb;
    assign m_axi.wlast   = wlast;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = bready;

endmodule

// File: tb/tb_axi_dma_w_burst.sv
// tb/tb_axi_dma_w_burst.sv - directed self-checking bench for axi_dma_w_burst
module tb_axi_dma_w_burst;
    import axi_dma_w_burst_pkg::*;

    localparam int ADDR_W = 32, DATA_W = 256, LEN_W = 8, MAX_BURST = 256, XFER_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                cmd_valid, cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [XFER_W-1:0]   cmd_beats;
    logic                s_valid, s_ready;
    logic [DATA_W-1:0]   s_data;
    logic [DATA_W/8-1:0] s_strb;
    logic                busy, done, error;

    axi_dma_w_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) axi ();

    axi_dma_w_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .XFER_W(XFER_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
        .busy(busy), .done(done), .error(error),
        .m_axi(axi)
    );

    int total = 0, bad = 0;
    logic [ADDR_W-1:0] aw_addr_q[$];
    logic [LEN_W-1:0]  aw_len_q[$];
    logic [DATA_W-1:0] w_data_q[$];
    bit                w_last_q[$];
    int done_cnt = 0, b_cnt = 0, wlast_cnt = 0, awv_cycles = 0, viol = 0;
    bit open_burst = 0;
    bit stall = 0;
    int err_target = -1, src_base = 0, src_total = 0;
    int b_issued = 0, b_seen = 0, wlast_seen = 0;
    int aw0, w0, d0;

    function automatic logic [DATA_W-1:0] pat(int i);
        logic [31:0] w;
        w = 32'(i) ^ 32'hC0DE0000;
        return {8{w}};
    endfunction

    // Observe bus traffic half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            open_burst = 0;
        end else begin
            if (axi.wvalid && !open_burst) viol++;
            if (axi.awvalid) awv_cycles++;
            if (axi.awvalid && axi.awready) begin
                aw_addr_q.push_back(axi.awaddr);
                aw_len_q.push_back(axi.awlen);
                open_burst = 1;
            end
            if (axi.wvalid && axi.wready) begin
                w_data_q.push_back(axi.wdata);
                w_last_q.push_back(axi.wlast);
                if (axi.wlast) begin
                    wlast_cnt++;
                    open_burst = 0;
                end
            end
            if (axi.bvalid && axi.bready) b_cnt++;
            if (done) done_cnt++;
        end
    end

    always begin
        @(posedge clk); #1;
        if (rst) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
            b_seen = b_cnt; wlast_seen = wlast_cnt;
        end else begin
            axi.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_cnt != b_seen) begin
                axi.bvalid = 1'b0;
                b_seen = b_cnt;
            end
            if (wlast_cnt != wlast_seen) begin
                wlast_seen = wlast_cnt;
                axi.bvalid = 1'b1;
                axi.bresp  = (b_issued == err_target) ? 2'b10 : 2'b00;
                b_issued++;
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (w_data_q.size() - src_base < src_total) begin
            s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = pat(w_data_q.size() - src_base);
        end else begin
            s_valid = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input int n, input bit st, input int err_rel);
        int cyc;
        aw0 = aw_addr_q.size(); w0 = w_data_q.size(); d0 = done_cnt;
        stall = st;
        err_target = (err_rel < 0) ? -1 : b_issued + err_rel;
        src_base = w0; src_total = n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = 16'(n);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_in_time", 64'(cyc < 4000), 64'd1);
        stall = 0;
    endtask

    task automatic chk_data(input string tag, input int n, input int bursts);
        int mism, lasts;
        mism = 0; lasts = 0;
        chk({tag, "_beats"}, 64'(w_data_q.size() - w0), 64'(n));
        for (int i = 0; i < n && w0 + i < w_data_q.size(); i++) begin
            if (w_data_q[w0 + i] !== pat(i)) mism++;
            if (w_last_q[w0 + i]) lasts++;
        end
        chk({tag, "_data"}, 64'(mism), 64'd0);
        chk({tag, "_wlast_cnt"}, 64'(lasts), 64'(bursts));
        if (w_data_q.size() >= w0 + n && n > 0)
            chk({tag, "_wlast_end"}, 64'(w_last_q[w0 + n - 1]), 64'd1);
    endtask

    task automatic chk_aw(input string tag, input int k, input logic [31:0] a, input logic [7:0] l);
        if (aw_addr_q.size() > aw0 + k) begin
            chk({tag, "_awaddr"}, 64'(aw_addr_q[aw0 + k]), 64'(a));
            chk({tag, "_awlen"}, 64'(aw_len_q[aw0 + k]), 64'(l));
        end else begin
            chk({tag, "_aw_missing"}, 64'(aw_addr_q.size()), 64'(aw0 + k + 1));
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] t3_addr[5];
        logic [7:0]  t3_len[5];
        t3_addr = '{32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h4000};
        t3_len  = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd87};
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; s_strb = '1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
        chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
        chk("rst_bready", 64'(axi.bready), 64'd0);
        chk("rst_awsize", 64'(axi.awsize), 64'd5);
        chk("rst_awburst", 64'(axi.awburst), 64'd1);
        chk("rst_awcache", 64'(axi.awcache), 64'd2);
        chk("rst_awprot", 64'(axi.awprot), 64'd2);
        rst = 1'b0;

        run(32'h1000, 16, 0, -1);
        chk("t1_aw_cnt", 64'(aw_addr_q.size() - aw0), 64'd1);
        chk_aw("t1", 0, 32'h1000, 8'd15);
        chk_data("t1", 16, 1);
        chk("t1_error", 64'(error), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);

        run(32'h1F9F, 16, 0, -1);
        chk("t2_aw_cnt", 64'(aw_addr_q.size() - aw0), 64'd2);
        chk_aw("t2_b0", 0, 32'h1F80, 8'd3);
        chk_aw("t2_b1", 1, 32'h2000, 8'd11);
        chk_data("t2", 16, 2);

        run(32'h0, 600, 0, -1);
        chk("t3_aw_cnt", 64'(aw_addr_q.size() - aw0), 64'd5);
        for (int k = 0; k < 5; k++) chk_aw($sformatf("t3_b%0d", k), k, t3_addr[k], t3_len[k]);
        chk_data("t3", 600, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_done_once", 64'(done_cnt - d0), 64'd1);

        run(32'h3000, 40, 1, -1);
        chk("t4_aw_cnt", 64'(aw_addr_q.size() - aw0), 64'd1);
        chk_aw("t4", 0, 32'h3000, 8'd39);
        chk_data("t4", 40, 1);
        chk("t4_wvalid_outside", 64'(viol), 64'd0);

        run(32'h1FC0, 140, 0, 1);
        chk("t5_aw_cnt", 64'(aw_addr_q.size() - aw0), 64'd3);
        chk_aw("t5_b0", 0, 32'h1FC0, 8'd1);
        chk_aw("t5_b1", 1, 32'h2000, 8'd127);
        chk_aw("t5_b2", 2, 32'h3000, 8'd9);
        chk_data("t5", 140, 3);
        chk("t5_error_sticky", 64'(error), 64'd1);

        cyc = awv_cycles;
        run(32'h100, 0, 0, -1);
        chk("t6_error_cleared", 64'(error), 64'd0);
        chk("t6_no_aw", 64'(aw_addr_q.size() - aw0), 64'd0);
        chk("t6_no_awvalid", 64'(awv_cycles - cyc), 64'd0);
        chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);

        aw0 = aw_addr_q.size(); w0 = w_data_q.size();
        src_base = w0; src_total = 16;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_beats = 16'd16;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (w_data_q.size() - w0 < 5 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t7_reach_beat5", 64'(w_data_q.size() - w0), 64'd5);
        rst = 1'b1;
        #1;
        chk("t7_awvalid", 64'(axi.awvalid), 64'd0);
        chk("t7_wvalid", 64'(axi.wvalid), 64'd0);
        chk("t7_wlast", 64'(axi.wlast), 64'd0);
        chk("t7_bready", 64'(axi.bready), 64'd0);
        chk("t7_s_ready", 64'(s_ready), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_error", 64'(error), 64'd0);
        src_total = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t7_cmd_ready_after", 64'(cmd_ready), 64'd1);
        chk("t7_busy_after", 64'(busy), 64'd0);

        run(32'h40, 4, 0, -1);
        chk("t8_aw_cnt", 64'(aw_addr_q.size() - aw0), 64'd1);
        chk_aw("t8", 0, 32'h40, 8'd3);
        chk_data("t8", 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
